// File: rtl/mfp_gpio_arbiter_if.sv
// Request/response bundle between NREQ requesters and mfp_gpio_arbiter.
// The master side is the requester pool; the slave side is the arbiter.
interface mfp_gpio_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 3
);
  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0]             req_write;
  logic [NREQ-1:0][ADDR_W-1:0] req_addr;
  logic [NREQ-1:0][31:0]       req_wdata;
  logic [NREQ-1:0]             req_ready;
  logic [NREQ-1:0]             rsp_valid;
  logic [31:0]                 rsp_rdata;
  logic                        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mfp_gpio_arbiter.sv
// Shares one GPIO register map between NREQ requesters: IDLE/ACCESS/RESP, one access per 3 cycles.
// Define MFP_GPIO_ARB_RR_EN for round-robin arbitration; default is fixed priority (lowest index).
module mfp_gpio_arbiter #(
  parameter int NREQ        = 2,
  parameter int GPIOW_COUNT = 5,
  parameter int GPIOR_COUNT = GPIOW_COUNT,
  parameter int ADDR_W      = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  mfp_gpio_arbiter_if.slave            bus,
  input  logic [GPIOR_COUNT-1:0][31:0] gpio_rd,
  output logic [31:0]                  gpio_wd,
  output logic [GPIOW_COUNT-1:0]       gpio_we
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Winner of the current IDLE cycle and its request fields
  logic              win_found;
  logic [IDX_W-1:0]  win_idx;
  logic [NREQ-1:0]   win_onehot;
  logic              win_write;
  logic [ADDR_W-1:0] win_addr;
  logic [31:0]       win_wdata;
  logic              accept;

  // Transaction captured at acceptance, consumed in ACCESS
  logic [IDX_W-1:0]  acc_idx;
  logic              acc_write;
  logic [ADDR_W-1:0] acc_addr;

  logic [GPIOW_COUNT-1:0] we_onehot;
  logic [31:0]            rd_sel;
  logic                   rd_hit;
  logic                   wr_hit;
  logic [NREQ-1:0]        rsp_onehot;

`ifdef MFP_GPIO_ARB_RR_EN
  // Last granted requester; starting at NREQ-1 gives requester 0 first turn.
  logic [IDX_W-1:0] rr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= IDX_W'(NREQ - 1);
    end else if (accept) begin
      rr_ptr <= win_idx;
    end
  end
`endif

  // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    win_write  = 1'b0;
    win_addr   = '0;
    win_wdata  = '0;
`ifdef MFP_GPIO_ARB_RR_EN
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!win_found && bus.req_valid[i] && (((int'(rr_ptr) + k) % NREQ) == i)) begin
          win_found     = 1'b1;
          win_idx       = IDX_W'(i);
          win_onehot[i] = 1'b1;
          win_write     = bus.req_write[i];
          win_addr      = bus.req_addr[i];
          win_wdata     = bus.req_wdata[i];
        end
      end
    end
`else
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found && bus.req_valid[i]) begin
        win_found     = 1'b1;
        win_idx       = IDX_W'(i);
        win_onehot[i] = 1'b1;
        win_write     = bus.req_write[i];
        win_addr      = bus.req_addr[i];
        win_wdata     = bus.req_wdata[i];
      end
    end
`endif
  end

  // Write strobe for the winner and read mux for the captured address
  always_comb begin
    we_onehot  = '0;
    rd_sel     = '0;
    rd_hit     = 1'b0;
    rsp_onehot = '0;
    for (int i = 0; i < GPIOW_COUNT; i++) begin
      we_onehot[i] = win_write && (32'(win_addr) == i);
    end
    for (int i = 0; i < GPIOR_COUNT; i++) begin
      if (32'(acc_addr) == i) begin
        rd_sel = gpio_rd[i];
        rd_hit = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      rsp_onehot[i] = (32'(acc_idx) == i);
    end
  end

  assign wr_hit = (32'(acc_addr) < GPIOW_COUNT);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    bus.req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = ACCESS;
          accept  = 1'b1;
          // Combinational grant is masked while reset is held so no requester sees a phantom accept.
          bus.req_ready = win_onehot & {NREQ{rst_n}};
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_idx       <= '0;
      acc_write     <= 1'b0;
      acc_addr      <= '0;
      gpio_wd       <= '0;
      gpio_we       <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      // Strobes and response fields are single-cycle pulses
      gpio_we       <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;

      if (accept) begin
        acc_idx   <= win_idx;
        acc_write <= win_write;
        acc_addr  <= win_addr;
        gpio_we   <= we_onehot;
        if (win_write) begin
          gpio_wd <= win_wdata;
        end
      end

      if (state_q == ACCESS) begin
        bus.rsp_valid <= rsp_onehot;
        bus.rsp_rdata <= (!acc_write && rd_hit) ? rd_sel : 32'd0;
        bus.rsp_err   <= acc_write ? !wr_hit : !rd_hit;
      end
    end
  end

`ifndef SYNTHESIS
  a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.req_ready));
  a_rsp_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.rsp_valid));
  a_we_in_access: assert property (@(posedge clk) disable iff (!rst_n)
    (gpio_we != '0) |-> (state_q == ACCESS && $onehot(gpio_we)));
`endif

endmodule
